// File: rtl/seq_mult_pkg.sv
// Shared state encoding, start-mode constants and latency helper for the
// seq_mult_n shift-add multiplier family.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   localparam int START_PULSE  = 0;
   localparam int START_CHANGE = 1;

   // Cycles from the accepting edge until valid/product are visible.
   function automatic int latency(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/seq_mult_n_start_qualifier.sv
// Turns the raw start input into a one-cycle request, either passing it
// through (pulse mode) or flagging any edge on it (change mode).
module start_qualifier
   import seq_mult_pkg::*;
#(
   parameter int START_MODE = START_PULSE
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic req
);

   logic prevStart_q;

   // Tracks start every cycle, busy or not, so a toggle while busy is consumed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prevStart_q <= 1'b0;
      end else begin
         prevStart_q <= start;
      end
   end

   assign req = (START_MODE == START_CHANGE) ? (start ^ prevStart_q) : start;

endmodule

// File: rtl/seq_mult_n.sv
// Radix-2 shift-add sequential multiplier with signed/unsigned operation,
// busy/valid handshake and a selectable start qualifier.
module seq_mult_n
   import seq_mult_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int START_MODE = START_PULSE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 valid,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   state_t                 state_q;
   logic [2*WIDTH-1:0]     acc_q;
   logic [2*WIDTH-1:0]     product_q;
   logic [WIDTH-1:0]       mcand_q;
   logic [CW-1:0]          count_q;
   logic                   negFlag_q;
   logic                   signed_q;
   logic                   valid_q;
   logic                   busy_q;

   logic                   req;
   logic                   accept;
   logic [WIDTH-1:0]       magA;
   logic [WIDTH-1:0]       magB;
   logic [WIDTH:0]         sum;

   start_qualifier #(
      .START_MODE (START_MODE)
   ) uStartQual (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .req   (req)
   );

   assign accept = req && ((state_q == IDLE) || (state_q == DONE));

   // The most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
   assign magA = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign magB = (signed_mode && b[WIDTH-1]) ? -b : b;

   assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         product_q <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
         negFlag_q <= 1'b0;
         signed_q  <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            RUN: begin
               acc_q   <= {sum, acc_q[WIDTH-1:1]};
               count_q <= count_q + CW'(1);
               if (count_q == LAST_COUNT) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               if (signed_q && negFlag_q) begin
                  acc_q <= -acc_q;
               end
               state_q <= DONE;
            end
            DONE: begin
               product_q <= acc_q;
               valid_q   <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // Acceptance overrides the IDLE/DONE defaults, giving back-to-back starts.
         if (accept) begin
            acc_q     <= {{WIDTH{1'b0}}, magB};
            mcand_q   <= magA;
            negFlag_q <= a[WIDTH-1] ^ b[WIDTH-1];
            signed_q  <= signed_mode;
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
         end
      end
   end

   assign product = product_q;
   assign valid   = valid_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// Scoreboard bench for seq_mult_n: one pulse-mode and one change-mode instance
// share operands; expected products are queued at issue and popped on valid.
module tb_seq_mult_n;
   import seq_mult_pkg::*;

   localparam int W   = 8;
   localparam int LAT = latency(W);

   logic          clk;
   logic          reset;
   logic          startP;
   logic          startC;
   logic          signedMode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2*W-1:0] prodP;
   logic [2*W-1:0] prodC;
   logic          validP;
   logic          validC;
   logic          busyP;
   logic          busyC;

   int checks   = 0;
   int failures = 0;
   logic [2*W-1:0] expQ[$];

   seq_mult_n #(.WIDTH(W), .START_MODE(START_PULSE)) dutP (
      .clk         (clk),
      .reset       (reset),
      .start       (startP),
      .signed_mode (signedMode),
      .a           (a),
      .b           (b),
      .product     (prodP),
      .valid       (validP),
      .busy        (busyP)
   );

   seq_mult_n #(.WIDTH(W), .START_MODE(START_CHANGE)) dutC (
      .clk         (clk),
      .reset       (reset),
      .start       (startC),
      .signed_mode (signedMode),
      .a           (a),
      .b           (b),
      .product     (prodC),
      .valid       (validC),
      .busy        (busyC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product computed with native integer arithmetic.
   function automatic logic [2*W-1:0] modelProd(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
      int px;
      int py;
      px = s ? int'($signed(x)) : int'(x);
      py = s ? int'($signed(y)) : int'(y);
      return (2*W)'(px * py);
   endfunction

   // Waits (bounded) for valid on the selected DUT; cyc = negedges elapsed, -1 on timeout.
   task automatic waitValid(input bit sel, output int cyc, output bit busyDropped);
      cyc = -1;
      busyDropped = 1'b0;
      for (int k = 1; k <= 4 * LAT; k++) begin
         @(negedge clk);
         if ((sel ? validC : validP) === 1'b1) begin
            cyc = k;
            break;
         end
         if ((sel ? busyC : busyP) !== 1'b1) busyDropped = 1'b1;
      end
   endtask

   task automatic popExp(output logic [2*W-1:0] e);
      if (expQ.size() == 0) e = 'x;
      else e = expQ.pop_front();
   endtask

   task automatic countValids(input bit sel, input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if ((sel ? validC : validP) === 1'b1) cnt++;
      end
   endtask

   task automatic startOp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
      @(negedge clk);
      a = ia;
      b = ib;
      signedMode = s;
      startP = 1'b1;
      @(negedge clk);
      startP = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({prodP, validP, busyP} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_pulse_dut: got prod=%h valid=%b busy=%b, want all 0", prodP, validP, busyP);
      end
      checks++;
      if ({prodC, validC, busyC} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_change_dut: got prod=%h valid=%b busy=%b, want all 0", prodC, validC, busyC);
      end
      reset = 1'b1;
   endtask

   task automatic test_unsigned_max();
      int cyc;
      bit bd;
      logic [2*W-1:0] e;
      expQ.push_back(16'hFE01);
      startOp(8'hFF, 8'hFF, 1'b0);
      waitValid(1'b0, cyc, bd);
      checks++;
      if (cyc != LAT) begin
         failures++;
         $display("[TB] FAIL umax_latency: got %0d cycles, want %0d", cyc, LAT);
      end
      checks++;
      if (bd) begin
         failures++;
         $display("[TB] FAIL umax_busy: busy dropped before valid, want held high");
      end
      checks++;
      if (busyP !== 1'b0) begin
         failures++;
         $display("[TB] FAIL umax_busy_clear: got busy=%b at valid, want 0", busyP);
      end
      popExp(e);
      checks++;
      if (prodP !== e) begin
         failures++;
         $display("[TB] FAIL umax_product: got %h, want %h", prodP, e);
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] ta[3] = '{8'hFD, 8'h80, 8'h80};
      logic [W-1:0] tb[3] = '{8'h05, 8'h80, 8'h7F};
      logic [2*W-1:0] te[3] = '{16'hFFF1, 16'h4000, 16'hC080};
      int cyc;
      bit bd;
      logic [2*W-1:0] e;
      for (int i = 0; i < 3; i++) begin
         expQ.push_back(te[i]);
         startOp(ta[i], tb[i], 1'b1);
         waitValid(1'b0, cyc, bd);
         popExp(e);
         checks++;
         if (cyc != LAT || prodP !== e) begin
            failures++;
            $display("[TB] FAIL signed_%0d: got prod=%h after %0d cycles, want %h after %0d", i, prodP, cyc, e, LAT);
         end
      end
   endtask

   task automatic test_random();
      int cyc;
      bit bd;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rs;
      logic [2*W-1:0] e;
      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rs = i[0];
         expQ.push_back(modelProd(ra, rb, rs));
         startOp(ra, rb, rs);
         waitValid(1'b0, cyc, bd);
         popExp(e);
         checks++;
         if (cyc != LAT || prodP !== e) begin
            failures++;
            $display("[TB] FAIL random_%0d (a=%h b=%h s=%b): got %h, want %h", i, ra, rb, rs, prodP, e);
         end
      end
   endtask

   task automatic test_ignore_run();
      int cyc;
      int cnt;
      bit bd;
      bit busyLow;
      logic [2*W-1:0] e;
      expQ.push_back(modelProd(8'd12, 8'd10, 1'b0));
      startOp(8'd12, 8'd10, 1'b0);
      busyLow = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (busyP !== 1'b1) busyLow = 1'b1;
         if (k == 2) begin
            a = 8'd200;
            b = 8'd200;
            startP = 1'b1;
         end else begin
            startP = 1'b0;
         end
      end
      waitValid(1'b0, cyc, bd);
      checks++;
      if (cyc + 3 != LAT || busyLow || bd) begin
         failures++;
         $display("[TB] FAIL ignore_timing: got valid at %0d busyLow=%b, want %0d and busy held", cyc + 3, busyLow | bd, LAT);
      end
      popExp(e);
      checks++;
      if (prodP !== e) begin
         failures++;
         $display("[TB] FAIL ignore_product: got %h, want %h", prodP, e);
      end
      countValids(1'b0, 2 * LAT, cnt);
      checks++;
      if (cnt != 0) begin
         failures++;
         $display("[TB] FAIL ignore_extra_valid: got %0d valids, want 0", cnt);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit bd;
      logic [2*W-1:0] e;
      int cnt;
      expQ.push_back(modelProd(8'd3, 8'd4, 1'b0));
      expQ.push_back(modelProd(8'hF0, 8'h0F, 1'b0));
      expQ.push_back(modelProd(8'h81, 8'h02, 1'b1));
      @(negedge clk);
      a = 8'd3;
      b = 8'd4;
      signedMode = 1'b0;
      startP = 1'b1;
      @(negedge clk);
      a = 8'hF0;
      b = 8'h0F;
      for (int i = 0; i < 3; i++) begin
         waitValid(1'b0, cyc, bd);
         popExp(e);
         checks++;
         if (cyc != LAT || prodP !== e) begin
            failures++;
            $display("[TB] FAIL b2b_%0d: got %h after %0d cycles, want %h after %0d", i, prodP, cyc, e, LAT);
         end
         checks++;
         if (busyP !== (i < 2 ? 1'b1 : 1'b0)) begin
            failures++;
            $display("[TB] FAIL b2b_busy_%0d: got busy=%b at valid, want %b", i, busyP, (i < 2));
         end
         if (i == 0) begin
            a = 8'h81;
            b = 8'h02;
            signedMode = 1'b1;
         end else if (i == 1) begin
            startP = 1'b0;
         end
      end
      countValids(1'b0, LAT + 2, cnt);
      checks++;
      if (cnt != 0) begin
         failures++;
         $display("[TB] FAIL b2b_stop: got %0d valids after release, want 0", cnt);
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      int cnt;
      bit bd;
      logic [2*W-1:0] e;
      startOp(8'd100, 8'd100, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({prodP, validP, busyP} !== '0) begin
         failures++;
         $display("[TB] FAIL midrun_reset: got prod=%h valid=%b busy=%b, want all 0", prodP, validP, busyP);
      end
      @(negedge clk);
      reset = 1'b1;
      countValids(1'b0, 2 * LAT, cnt);
      checks++;
      if (cnt != 0) begin
         failures++;
         $display("[TB] FAIL midrun_no_valid: got %0d valids, want 0", cnt);
      end
      expQ.push_back(16'd42);
      startOp(8'd7, 8'd6, 1'b0);
      waitValid(1'b0, cyc, bd);
      popExp(e);
      checks++;
      if (cyc != LAT || prodP !== e) begin
         failures++;
         $display("[TB] FAIL midrun_recover: got %h after %0d cycles, want %h", prodP, cyc, e);
      end
   endtask

   task automatic test_change_mode();
      int cyc;
      int cnt;
      bit bd;
      logic [2*W-1:0] e;
      for (int i = 0; i < 2; i++) begin
         expQ.push_back(modelProd(8'd9 + W'(i), 8'd11, 1'b0));
         @(negedge clk);
         a = 8'd9 + W'(i);
         b = 8'd11;
         signedMode = 1'b0;
         startC = ~startC;
         @(negedge clk);
         waitValid(1'b1, cyc, bd);
         popExp(e);
         checks++;
         if (cyc != LAT || prodC !== e) begin
            failures++;
            $display("[TB] FAIL change_op_%0d: got %h after %0d cycles, want %h", i, prodC, cyc, e);
         end
         countValids(1'b1, LAT + 4, cnt);
         checks++;
         if (cnt != 0) begin
            failures++;
            $display("[TB] FAIL change_steady_%0d: got %0d valids with start steady, want 0", i, cnt);
         end
      end
      @(negedge clk);
      startC = ~startC;
      repeat (3) @(negedge clk);
      startC = ~startC;
      countValids(1'b1, 3 * LAT, cnt);
      checks++;
      if (cnt != 1) begin
         failures++;
         $display("[TB] FAIL change_busy_toggle: got %0d valids, want 1", cnt);
      end
   endtask

   initial begin
      reset = 1'b0;
      startP = 1'b0;
      startC = 1'b0;
      signedMode = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_unsigned_max();
      test_signed();
      test_random();
      test_ignore_run();
      test_back_to_back();
      test_reset_midrun();
      test_change_mode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
